// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: shared encodings and helpers for the acc_seq accumulator sequencer.
//   op_t     command opcodes carried on in_op
//   state_t  handshake FSM states
//   cmd_t    command captured at acceptance
//   signed_ovf  two's-complement overflow of a 4-bit add with pre-inverted operand
package acc_seq_pkg;

    localparam int ACC_W = 4;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef struct packed {
        op_t              op;
        logic [ACC_W-1:0] data;
    } cmd_t;

    // Overflow when both effective operands share a sign and the result's sign differs.
    function automatic logic signed_ovf(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b_eff,
        input logic [ACC_W-1:0] r
    );
        return (a[ACC_W-1] == b_eff[ACC_W-1]) && (r[ACC_W-1] != a[ACC_W-1]);
    endfunction

endpackage

// File: rtl/acc_seq_addsub.sv
// acc_seq_addsub: 4-bit adder/subtractor, result = operand_a +/- operand_b mod 16.
//   result     out  sum (mode=0) or difference (mode=1)
//   operand_a  in   first operand
//   operand_b  in   second operand
//   mode       in   0 add, 1 subtract
module acc_seq_addsub (
    output logic [3:0] result,
    input  logic [3:0] operand_a,
    input  logic [3:0] operand_b,
    input  logic       mode
);

    // Subtraction as a + ~b + 1, so one carry chain serves both modes.
    always_comb result = operand_a + (operand_b ^ {4{mode}}) + {3'b000, mode};

endmodule

// File: rtl/acc_seq.sv
// acc_seq: handshake-driven 4-bit accumulator executing LOAD/ADD/SUB/CLEAR commands.
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  command handshake; in_op opcode, in_data signed operand
//   out_valid/ready response handshake
//   out_acc         accumulator after last command; out_ovf its signed overflow
//   out_zero        out_acc == 0; out_sticky OR of overflows since CLEAR/reset
//   op_count        executed-command counter, wraps at 2^CNT_W
module acc_seq
    import acc_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [3:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_acc,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_sticky,
    output logic [CNT_W-1:0] op_count
);

    state_t           state, state_nx;
    cmd_t             cmd;
    logic [ACC_W-1:0] acc, sum, b_eff;
    logic             ovf, sticky, mode, arith, is_load, is_clear, ovf_nx;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb
        state_nx = (state == IDLE) ? (in_valid ? EXEC : IDLE) :
                   (state == EXEC) ? RESP :
                   (out_ready ? IDLE : RESP);

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == RESP);
    end

    always_comb begin
        mode     = (cmd.op == OP_SUB);
        is_load  = (cmd.op == OP_LOAD);
        is_clear = (cmd.op == OP_CLEAR);
        arith    = !is_load && !is_clear;
        b_eff    = cmd.data ^ {ACC_W{mode}};
        ovf_nx   = arith && signed_ovf(acc, b_eff, sum);
    end

    acc_seq_addsub u_addsub (
        .result    (sum),
        .operand_a (acc),
        .operand_b (cmd.data),
        .mode      (mode)
    );

    // Command is latched only on the IDLE handshake, so input traffic during
    // EXEC/RESP cannot disturb the operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd    <= '{op: OP_LOAD, data: '0};
            acc    <= '0;
            ovf    <= 1'b0;
            sticky <= 1'b0;
            cnt    <= '0;
        end else begin
            if (in_ready && in_valid) begin
                cmd.op   <= op_t'(in_op);
                cmd.data <= in_data;
            end
            if (state == EXEC) begin
                acc    <= is_load ? cmd.data : is_clear ? '0 : sum;
                ovf    <= ovf_nx;
                sticky <= is_clear ? 1'b0 : (sticky | ovf_nx);
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        out_acc    = acc;
        out_ovf    = ovf;
        out_sticky = sticky;
        out_zero   = (acc == '0);
        op_count   = cnt;
    end

endmodule

// File: tb/tb_acc_seq.sv
// tb_acc_seq: directed + randomized self-checking bench for acc_seq against an integer model.
module tb_acc_seq;

    logic       clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [1:0] in_op;
    logic [3:0] in_data, out_acc;
    logic       out_ovf, out_zero, out_sticky;
    logic [7:0] op_count;

    int tests = 0;
    int fails = 0;

    int m_acc, m_ovf, m_sticky, m_cnt;

    acc_seq #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_sticky(out_sticky), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sext(input logic [3:0] d);
        return (d >= 8) ? int'(d) - 16 : int'(d);
    endfunction

    task automatic model_reset();
        m_acc = 0; m_ovf = 0; m_sticky = 0; m_cnt = 0;
    endtask

    task automatic model(input logic [1:0] op, input logic [3:0] d);
        int s;
        if (op == 2'b00) begin
            m_acc = sext(d); m_ovf = 0;
        end else if (op == 2'b11) begin
            m_acc = 0; m_ovf = 0; m_sticky = 0;
        end else begin
            s = (op == 2'b01) ? m_acc + sext(d) : m_acc - sext(d);
            m_ovf = (s > 7 || s < -8) ? 1 : 0;
            m_acc = (s > 7) ? s - 16 : (s < -8) ? s + 16 : s;
        end
        if (op != 2'b11) m_sticky = m_sticky | m_ovf;
        m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic chk_outputs(input string tag);
        logic [3:0] ma;
        ma = m_acc[3:0];
        chk({tag, "_acc"}, out_acc, ma);
        chk({tag, "_ovf"}, out_ovf, m_ovf);
        chk({tag, "_zero"}, out_zero, (m_acc == 0));
        chk({tag, "_sticky"}, out_sticky, m_sticky);
        chk({tag, "_cnt"}, op_count, m_cnt);
    endtask

    // One full command; in_valid stays high with junk after acceptance so any
    // double capture shows up in the counter and accumulator.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input int stall);
        logic [3:0] held;
        @(negedge clk);
        chk("idle_ready", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_data = d;
        @(posedge clk); #1;
        in_op = 2'($urandom); in_data = 4'($urandom);
        @(negedge clk);
        chk("exec_valid", out_valid, 0);
        chk("exec_ready", in_ready, 0);
        model(op, d);
        @(posedge clk); #1;
        in_op = 2'($urandom); in_data = 4'($urandom);
        @(negedge clk);
        chk("resp_valid", out_valid, 1);
        chk("resp_ready", in_ready, 0);
        chk_outputs("resp");
        held = out_acc;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            in_op = 2'($urandom); in_data = 4'($urandom);
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_ready", in_ready, 0);
            chk("stall_acc_stable", out_acc, held);
            chk_outputs("stall");
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_valid", out_valid, 0);
        chk("post_ready", in_ready, 1);
        chk_outputs("post");
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = 2'b00; in_data = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_acc", out_acc, 0);
        chk("rst_zero", out_zero, 1);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_sticky", out_sticky, 0);
        chk("rst_cnt", op_count, 0);
        #1 rst = 1'b0;
        model_reset();

        // LOAD 5; ADD 3 -> 8 with overflow
        do_cmd(2'b00, 4'd5, 0);
        do_cmd(2'b01, 4'd3, 0);
        chk("d1_acc", out_acc, 4'h8);
        chk("d1_ovf", out_ovf, 1);
        chk("d1_sticky", out_sticky, 1);
        chk("d1_cnt", op_count, 2);

        // LOAD -8; SUB 1 -> 7 with overflow; CLEAR
        do_cmd(2'b00, 4'h8, 1);
        do_cmd(2'b10, 4'd1, 0);
        chk("d2_acc", out_acc, 4'h7);
        chk("d2_ovf", out_ovf, 1);
        do_cmd(2'b11, 4'hf, 0);
        chk("d2_clr_acc", out_acc, 0);
        chk("d2_clr_zero", out_zero, 1);
        chk("d2_clr_sticky", out_sticky, 0);

        // LOAD 3; SUB 3 -> 0, no overflow; long stall in RESP
        do_cmd(2'b00, 4'd3, 5);
        do_cmd(2'b10, 4'd3, 5);
        chk("d3_acc", out_acc, 0);
        chk("d3_zero", out_zero, 1);
        chk("d3_ovf", out_ovf, 0);
        chk("d3_cnt", op_count, 7);

        // Reset during EXEC of ADD 2 discards the command
        do_cmd(2'b00, 4'd4, 0);
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b01; in_data = 4'd2;
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rx_ready", in_ready, 1);
        chk("rx_valid", out_valid, 0);
        chk_outputs("rx");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rx_no_valid", out_valid, 0);
        end

        // Reset during RESP with out_ready also high: reset wins
        do_cmd(2'b00, 4'd6, 0);
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b01; in_data = 4'd1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rr_valid", out_valid, 0);
        chk("rr_ready", in_ready, 1);
        chk_outputs("rr");

        // Randomized commands with random RESP stalls
        for (int i = 0; i < 60; i++)
            do_cmd(2'($urandom), 4'($urandom), int'($urandom_range(0, 3)));

        // 256 ADD 1 from reset: counter and accumulator both wrap
        do_reset();
        for (int i = 0; i < 256; i++) do_cmd(2'b01, 4'd1, 0);
        chk("w_cnt", op_count, 0);
        chk("w_acc", out_acc, 0);
        chk("w_sticky", out_sticky, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
